// File: rtl/key_repeat_if.sv
// Key-repeat bus: USB key slots and pause flag in, per-player move pulses and facing out.
interface key_repeat_if;
    localparam int unsigned KEY_W = 8;
    localparam int unsigned DIR_W = 2;

    logic             enable;
    logic [KEY_W-1:0] keycode0;
    logic [KEY_W-1:0] keycode1;
    logic [KEY_W-1:0] keycode_p1;
    logic [KEY_W-1:0] keycode_p2;
    logic [DIR_W-1:0] facing_p1;
    logic [DIR_W-1:0] facing_p2;

    // Stimulus side (keyboard / game controller)
    modport master (
        output enable,
        output keycode0,
        output keycode1,
        input  keycode_p1,
        input  keycode_p2,
        input  facing_p1,
        input  facing_p2
    );

    // Key-repeat block side
    modport slave (
        input  enable,
        input  keycode0,
        input  keycode1,
        output keycode_p1,
        output keycode_p2,
        output facing_p1,
        output facing_p2
    );
endinterface

// File: rtl/key_repeat.sv
// Typematic key repeat for two tank players sharing one USB keyboard.
// Each player gets a one-frame move pulse on press, then repeats after
// INIT_DELAY frames and every REPEAT_PERIOD frames while the key is held.
module key_repeat #(
    parameter int unsigned INIT_DELAY    = 12,
    parameter int unsigned REPEAT_PERIOD = 6
) (
    input  logic         frame_clk,
    input  logic         Reset_n,
    key_repeat_if.slave  bus
);

    localparam int unsigned KEY_W = 8;
    localparam int unsigned DIR_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NUM_P = 2;

    localparam logic [KEY_W-1:0] KEY_NONE = 8'h00;
    localparam logic [DIR_W-1:0] DIR_UP   = 2'd0;
    localparam logic [DIR_W-1:0] DIR_RT   = 2'd1;
    localparam logic [DIR_W-1:0] DIR_DN   = 2'd2;
    localparam logic [DIR_W-1:0] DIR_LT   = 2'd3;

    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    state_e           state_q [NUM_P];
    state_e           state_d [NUM_P];
    logic [KEY_W-1:0] held_q  [NUM_P];
    logic [KEY_W-1:0] held_d  [NUM_P];
    logic [CNT_W-1:0] cnt_q   [NUM_P];
    logic [CNT_W-1:0] cnt_d   [NUM_P];
    logic [KEY_W-1:0] out_q   [NUM_P];
    logic [KEY_W-1:0] out_d   [NUM_P];
    logic [DIR_W-1:0] face_q  [NUM_P];
    logic [DIR_W-1:0] face_d  [NUM_P];
    logic [KEY_W-1:0] sel_c   [NUM_P];

    // Player 1 key set: W D S A
    function automatic logic is_p1_key(input logic [KEY_W-1:0] code);
        return (code == 8'h1A) || (code == 8'h07) || (code == 8'h16) || (code == 8'h04);
    endfunction

    // Player 2 key set: arrow keys
    function automatic logic is_p2_key(input logic [KEY_W-1:0] code);
        return (code == 8'h52) || (code == 8'h4F) || (code == 8'h51) || (code == 8'h50);
    endfunction

    // Direction of a valid move key; only called with member keys
    function automatic logic [DIR_W-1:0] dir_of(input logic [KEY_W-1:0] code);
        logic [DIR_W-1:0] d;
        d = DIR_UP;
        case (code)
            8'h1A, 8'h52: d = DIR_UP;
            8'h07, 8'h4F: d = DIR_RT;
            8'h16, 8'h51: d = DIR_DN;
            8'h04, 8'h50: d = DIR_LT;
            default:      d = DIR_UP;
        endcase
        return d;
    endfunction

    // Per-player key selection: slot 0 wins over slot 1 when both belong to the player
    always_comb begin
        sel_c[0] = KEY_NONE;
        sel_c[1] = KEY_NONE;
        if (is_p1_key(bus.keycode0)) begin
            sel_c[0] = bus.keycode0;
        end else if (is_p1_key(bus.keycode1)) begin
            sel_c[0] = bus.keycode1;
        end
        if (is_p2_key(bus.keycode0)) begin
            sel_c[1] = bus.keycode0;
        end else if (is_p2_key(bus.keycode1)) begin
            sel_c[1] = bus.keycode1;
        end
    end

    // Next-state and pulse logic, identical for both players
    always_comb begin
        for (int p = 0; p < NUM_P; p++) begin
            state_d[p] = state_q[p];
            held_d[p]  = held_q[p];
            cnt_d[p]   = cnt_q[p];
            out_d[p]   = KEY_NONE;
            face_d[p]  = face_q[p];

            if (!bus.enable) begin
                // Paused: drop to idle so a key still held on resume is a fresh press
                state_d[p] = ST_IDLE;
            end else begin
                case (state_q[p])
                    ST_IDLE: begin
                        if (sel_c[p] != KEY_NONE) begin
                            state_d[p] = ST_DELAY;
                            held_d[p]  = sel_c[p];
                            cnt_d[p]   = INIT_LOAD;
                            out_d[p]   = sel_c[p];
                            face_d[p]  = dir_of(sel_c[p]);
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (sel_c[p] == KEY_NONE) begin
                            state_d[p] = ST_IDLE;
                        end else if (sel_c[p] != held_q[p]) begin
                            // Direction change restarts as a press with no idle gap
                            state_d[p] = ST_DELAY;
                            held_d[p]  = sel_c[p];
                            cnt_d[p]   = INIT_LOAD;
                            out_d[p]   = sel_c[p];
                            face_d[p]  = dir_of(sel_c[p]);
                        end else if (cnt_q[p] != '0) begin
                            cnt_d[p] = cnt_q[p] - CNT_W'(1);
                        end else begin
                            state_d[p] = ST_REPEAT;
                            cnt_d[p]   = REPEAT_LOAD;
                            out_d[p]   = held_q[p];
                            face_d[p]  = dir_of(held_q[p]);
                        end
                    end
                    default: begin
                        state_d[p] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State, held key, counter, pulse and facing registers
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_P; p++) begin
                state_q[p] <= ST_IDLE;
                held_q[p]  <= KEY_NONE;
                cnt_q[p]   <= '0;
                out_q[p]   <= KEY_NONE;
            end
            face_q[0] <= DIR_UP;
            face_q[1] <= DIR_DN;
        end else begin
            for (int p = 0; p < NUM_P; p++) begin
                state_q[p] <= state_d[p];
                held_q[p]  <= held_d[p];
                cnt_q[p]   <= cnt_d[p];
                out_q[p]   <= out_d[p];
                face_q[p]  <= face_d[p];
            end
        end
    end

    assign bus.keycode_p1 = out_q[0];
    assign bus.keycode_p2 = out_q[1];
    assign bus.facing_p1  = face_q[0];
    assign bus.facing_p2  = face_q[1];

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat: default timing instance plus a 1/1 timing instance.
module tb_key_repeat;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b1;
    int   total = 0;
    int   bad   = 0;

    key_repeat_if ifc ();
    key_repeat_if ifq ();

    key_repeat dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (ifc.slave)
    );

    key_repeat #(.INIT_DELAY(1), .REPEAT_PERIOD(1)) dut_fast (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (ifq.slave)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it
    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic keys(input logic [7:0] k0, input logic [7:0] k1);
        ifc.keycode0 = k0;
        ifc.keycode1 = k1;
    endtask

    initial begin
        logic [7:0] e;
        ifc.enable = 1'b1; ifc.keycode0 = 8'h00; ifc.keycode1 = 8'h00;
        ifq.enable = 1'b1; ifq.keycode0 = 8'h00; ifq.keycode1 = 8'h00;

        // Asynchronous reset values
        #1 Reset_n = 1'b0;
        #2;
        chk("rst_p1", ifc.keycode_p1, 8'h00);
        chk("rst_p2", ifc.keycode_p2, 8'h00);
        chk("rst_face1", 8'(ifc.facing_p1), 8'd0);
        chk("rst_face2", 8'(ifc.facing_p2), 8'd2);
        step();
        Reset_n = 1'b1;
        step();

        // Held 1A for 30 edges: pulses on 1, 13, 19, 25
        keys(8'h1A, 8'h00);
        for (int c = 1; c <= 30; c++) begin
            step();
            e = (c == 1 || c == 13 || c == 19 || c == 25) ? 8'h1A : 8'h00;
            chk($sformatf("hold1A_c%0d", c), ifc.keycode_p1, e);
            chk($sformatf("hold1A_p2_c%0d", c), ifc.keycode_p2, 8'h00);
        end
        chk("hold1A_face1", 8'(ifc.facing_p1), 8'd0);
        keys(8'h00, 8'h00);
        step();
        chk("rel1A_p1", ifc.keycode_p1, 8'h00);
        chk("rel1A_face1", 8'(ifc.facing_p1), 8'd0);

        // Both players at once
        keys(8'h04, 8'h4F);
        step();
        chk("dual_p1", ifc.keycode_p1, 8'h04);
        chk("dual_p2", ifc.keycode_p2, 8'h4F);
        chk("dual_face1", 8'(ifc.facing_p1), 8'd3);
        chk("dual_face2", 8'(ifc.facing_p2), 8'd1);
        keys(8'h00, 8'h00);
        step();
        chk("dual_rel_p1", ifc.keycode_p1, 8'h00);
        chk("dual_rel_face2", 8'(ifc.facing_p2), 8'd1);

        // 07 for 5 edges then switch to 16
        keys(8'h07, 8'h00);
        step();
        chk("sw_07_first", ifc.keycode_p1, 8'h07);
        chk("sw_face_rt", 8'(ifc.facing_p1), 8'd1);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk($sformatf("sw_07_c%0d", c), ifc.keycode_p1, 8'h00);
        end
        keys(8'h16, 8'h00);
        step();
        chk("sw_16_edge", ifc.keycode_p1, 8'h16);
        chk("sw_face_dn", 8'(ifc.facing_p1), 8'd2);
        for (int c = 1; c <= 12; c++) begin
            step();
            e = (c == 12) ? 8'h16 : 8'h00;
            chk($sformatf("sw_16_c%0d", c), ifc.keycode_p1, e);
        end
        keys(8'h00, 8'h00);
        step();

        // Reset in the middle of repeat, with both players held
        keys(8'h1A, 8'h52);
        for (int c = 1; c <= 13; c++) step();
        chk("rr_p1_c13", ifc.keycode_p1, 8'h1A);
        chk("rr_p2_c13", ifc.keycode_p2, 8'h52);
        chk("rr_face2_up", 8'(ifc.facing_p2), 8'd0);
        #1 Reset_n = 1'b0;
        #1;
        chk("rr_async_p1", ifc.keycode_p1, 8'h00);
        chk("rr_async_p2", ifc.keycode_p2, 8'h00);
        chk("rr_async_face1", 8'(ifc.facing_p1), 8'd0);
        chk("rr_async_face2", 8'(ifc.facing_p2), 8'd2);
        Reset_n = 1'b1;
        step();
        chk("rr_new_p1", ifc.keycode_p1, 8'h1A);
        chk("rr_new_p2", ifc.keycode_p2, 8'h52);
        chk("rr_new_face2", 8'(ifc.facing_p2), 8'd0);
        step();
        chk("rr_quiet_p1", ifc.keycode_p1, 8'h00);
        keys(8'h00, 8'h00);
        step();

        // Slot priority within one player
        keys(8'h16, 8'h1A);
        step();
        chk("prio_p1", ifc.keycode_p1, 8'h16);
        chk("prio_face1", 8'(ifc.facing_p1), 8'd2);
        chk("prio_p2", ifc.keycode_p2, 8'h00);
        keys(8'h00, 8'h00);
        step();

        // Unmapped key
        keys(8'h2C, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("ign_p1_c%0d", c), ifc.keycode_p1, 8'h00);
            chk($sformatf("ign_p2_c%0d", c), ifc.keycode_p2, 8'h00);
        end
        chk("ign_face1", 8'(ifc.facing_p1), 8'd2);
        chk("ign_face2", 8'(ifc.facing_p2), 8'd0);
        keys(8'h00, 8'h00);
        step();

        // Pause while held, then resume
        keys(8'h07, 8'h00);
        step();
        chk("pause_press", ifc.keycode_p1, 8'h07);
        for (int c = 2; c <= 5; c++) step();
        ifc.enable = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
            chk($sformatf("pause_c%0d", c), ifc.keycode_p1, 8'h00);
        end
        chk("pause_face1", 8'(ifc.facing_p1), 8'd1);
        ifc.enable = 1'b1;
        step();
        chk("resume_press", ifc.keycode_p1, 8'h07);
        keys(8'h00, 8'h00);
        step();

        // 1/1 timing: every edge pulses while held
        ifq.keycode0 = 8'h50;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("fast_p2_c%0d", c), ifq.keycode_p2, 8'h50);
        end
        chk("fast_face2", 8'(ifq.facing_p2), 8'd3);
        ifq.keycode0 = 8'h00;
        step();
        chk("fast_rel", ifq.keycode_p2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 Parameter INIT_DELAY, default 12, means frames from first move pulse to first repeat pulse while a key is held (legal range 1..255).
REQ-002 Parameter REPEAT_PERIOD, default 6, means frames between repeat pulses after the first repeat (legal range 1..255).
REQ-003 Port frame_clk  input  1  is the sole clock; all state updates on its rising edge.
REQ-004 Port Reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port enable  input  1  is the game-running flag; low means paused.
REQ-006 Port keycode0  input  8  is the USB key slot 0, highest priority; 8'h00 means empty.
REQ-007 Port keycode1  input  8  is the USB key slot 1, lower priority; 8'h00 means empty.
REQ-008 Port keycode_p1  output  8  is the player-1 move pulse keycode, fed to the player-1 tank; 8'h00 means no move.
REQ-009 Port keycode_p2  output  8  is the player-2 move pulse keycode, fed to the player-2 tank.
REQ-010 Port facing_p1  output  2  is the player-1 last direction (0 up, 1 right, 2 down, 3 left).
REQ-011 Port facing_p2  output  2  is the player-2 last direction, same encoding.

Function
REQ-012 Key sets SHALL be: P1 {1A up, 07 right, 16 down, 04 left} and P2 {52 up, 4F right, 51 down, 50 left}; all other codes SHALL be ignored.
REQ-013 Per player, sel SHALL be keycode0 if it is in that player's set, else keycode1 if it is in that player's set, else 8'h00; both players SHALL be evaluated independently on the same cycle.
REQ-014 Each player SHALL have an identical, independent FSM with states IDLE, DELAY and REPEAT, a registered held-key copy, and an 8-bit down-counter.
REQ-015 IDLE with sel nonzero: output SHALL be sel for exactly one cycle, held SHALL load sel, the counter SHALL load INIT_DELAY-1, and the FSM SHALL go to DELAY.
REQ-016 DELAY or REPEAT with sel equal to held and counter nonzero: the counter SHALL decrement and the output SHALL be 8'h00.
REQ-017 DELAY or REPEAT with sel equal to held and counter zero: output SHALL be held for one cycle, the counter SHALL load REPEAT_PERIOD-1, and the FSM SHALL go to REPEAT.
REQ-018 DELAY or REPEAT with sel equal to 8'h00 (release): the FSM SHALL go to IDLE and the output SHALL be 8'h00 on that edge.
REQ-019 DELAY or REPEAT with sel nonzero and different from held (direction change): the FSM SHALL behave as IDLE-with-press (REQ-015) on the same edge, with no idle cycle.
REQ-020 Outputs SHALL be registered; the output reflects the input sampled at the same edge (latency 1 edge), and no cycle SHALL carry a nonzero pulse other than those defined in REQ-015, REQ-017 and REQ-019.
REQ-021 facing_pX SHALL update to the direction of every nonzero pulse on the same edge the pulse is registered, and SHALL hold its value on release.
REQ-022 enable low SHALL force both FSMs to IDLE and both keycode outputs to 8'h00 on the next edge, with facing held; a key held when enable rises SHALL be treated as a new press.
REQ-023 REPEAT_PERIOD=1 SHALL pulse every cycle while held; INIT_DELAY=1 SHALL repeat on the cycle after the first pulse.

Reset
REQ-024 Reset_n low SHALL immediately, without a clock, set both FSMs to IDLE, both keycode outputs to 8'h00, held and counters to 0, facing_p1 to 0 (up) and facing_p2 to 2 (down).
REQ-025 Reset_n asserted mid-DELAY or mid-REPEAT SHALL abort the operation; after release, a still-held key SHALL be treated as a new press.

Verification
REQ-026 Scenario: keycode0=1A held for 30 cycles with enable=1 and defaults -> keycode_p1=1A on cycles 1, 13, 19 and 25 (counting edges from the press), 00 otherwise, and facing_p1=0.
REQ-027 Scenario: keycode0=04 and keycode1=4F held -> P1 and P2 pulse simultaneously on cycle 1, facing_p1=3, facing_p2=1.
REQ-028 Scenario: 07 held for 5 cycles, then switched to 16 -> 16 pulse on the switch edge, next 16 pulse 12 cycles later, facing_p1 changes 1 to 2.
REQ-029 Scenario: key held, Reset_n pulsed low mid-REPEAT -> outputs 00 asynchronously, facing_p1=0, facing_p2=2; on reset release the held key pulses on the first edge.
REQ-030 Scenario: keycode0=16 and keycode1=1A (both P1) -> 16 selected; 0x2C alone -> no pulse on either player; enable dropped while held -> outputs 00, facing unchanged.
